// File: rtl/rbz_update_pkg.sv
// -----------------------------------------------------------------------------
// rbz_update_pkg
// Shared definitions for the frame-synchronous update arbiter:
//   state_t      - commit FSM states
//   WR_SEL_VEC   - o_wr_sel value for a vector write
//   WR_SEL_REG   - o_wr_sel value for a register write
//   cnt_w()      - width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package rbz_update_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEC,
        ST_REG,
        ST_DONE
    } state_t;

    localparam logic WR_SEL_VEC = 1'b0;
    localparam logic WR_SEL_REG = 1'b1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rbz_update_arbiter_if.sv
// -----------------------------------------------------------------------------
// rbz_update_arbiter_if
// Bundles the requester inputs and the shared write-port outputs of
// rbz_update_arbiter.
//   master : requester / timing side (drives i_*, observes o_*)
//   slave  : the arbiter itself (observes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface rbz_update_arbiter_if #(
    parameter int VEC_W  = 48,
    parameter int REG_W  = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4
);
    import rbz_update_pkg::*;

    logic                      i_vblank;
    logic                      i_vec_valid;
    logic [VEC_W-1:0]          i_vec_data;
    logic                      i_reg_valid;
    logic [REG_AW-1:0]         i_reg_addr;
    logic [REG_W-1:0]          i_reg_data;
    logic                      o_reg_ready;
    logic                      o_wr_en;
    logic                      o_wr_sel;
    logic [REG_AW-1:0]         o_wr_addr;
    logic [VEC_W-1:0]          o_wr_data;
    logic                      o_vec_pending;
    logic [cnt_w(DEPTH)-1:0]   o_reg_count;
    logic                      o_vec_dropped;
    logic                      o_frame_done;

    modport master (
        output i_vblank, i_vec_valid, i_vec_data, i_reg_valid, i_reg_addr, i_reg_data,
        input  o_reg_ready, o_wr_en, o_wr_sel, o_wr_addr, o_wr_data,
               o_vec_pending, o_reg_count, o_vec_dropped, o_frame_done
    );

    modport slave (
        input  i_vblank, i_vec_valid, i_vec_data, i_reg_valid, i_reg_addr, i_reg_data,
        output o_reg_ready, o_wr_en, o_wr_sel, o_wr_addr, o_wr_data,
               o_vec_pending, o_reg_count, o_vec_dropped, o_frame_done
    );

endinterface

// File: rtl/rbz_sync_fifo.sv
// -----------------------------------------------------------------------------
// rbz_sync_fifo
// Single-clock FIFO with synchronous active-high reset.
//   clk, reset : clock, synchronous reset (empties the FIFO)
//   push, din  : write request / data (ignored while full)
//   pop, dout  : read request / head of queue (ignored while empty)
//   count      : registered occupancy, 0..DEPTH
//   empty/full : derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module rbz_sync_fifo
    import rbz_update_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    empty,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    // Full comes from the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // NOTE: storage is not reset; only pointers and count are, which is
    // enough to make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rbz_update_arbiter.sv
// -----------------------------------------------------------------------------
// rbz_update_arbiter
// Buffers vector and register updates from the two SPI decoders and commits
// them through one shared write port during vertical blanking only, so the
// renderer never sees a half-updated view.
//   clk, reset : pixel clock, synchronous active-high reset
//   bus        : rbz_update_arbiter_if.slave (requests in, write port out)
// Commit order per frame: buffered vector first, then queued register writes
// in FIFO order. All o_wr_* outputs are registered.
// -----------------------------------------------------------------------------
module rbz_update_arbiter
    import rbz_update_pkg::*;
#(
    parameter int VEC_W  = 48,
    parameter int REG_W  = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rbz_update_arbiter_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);

    state_t              state;
    logic                vblank_q;
    logic                vblank_rise;
    logic                pending;
    logic [VEC_W-1:0]    vec_buf;
    logic                wr_en;
    logic                wr_sel;
    logic [REG_AW-1:0]   wr_addr;
    logic [VEC_W-1:0]    wr_data;
    logic                dropped;
    logic                frame_done;

    logic                fifo_pop;
    logic [REG_AW+REG_W-1:0] fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic [REG_AW-1:0]   head_addr;
    logic [REG_W-1:0]    head_data;

    rbz_sync_fifo #(
        .WIDTH (REG_AW + REG_W),
        .DEPTH (DEPTH)
    ) u_reg_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.i_reg_valid),
        .pop   (fifo_pop),
        .din   ({bus.i_reg_addr, bus.i_reg_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign {head_addr, head_data} = fifo_dout;
    assign vblank_rise = bus.i_vblank && !vblank_q;
    // Pop only while vblank is still high; a window that closes mid-drain
    // leaves the remaining entries for the next frame.
    assign fifo_pop = (state == ST_REG) && bus.i_vblank && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            vblank_q   <= 1'b0;
            pending    <= 1'b0;
            vec_buf    <= '0;
            wr_en      <= 1'b0;
            wr_sel     <= WR_SEL_VEC;
            wr_addr    <= '0;
            wr_data    <= '0;
            dropped    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vblank_q   <= bus.i_vblank;
            wr_en      <= 1'b0;
            wr_sel     <= WR_SEL_VEC;
            wr_addr    <= '0;
            wr_data    <= '0;
            dropped    <= 1'b0;
            frame_done <= 1'b0;

            // Latest vector wins; it only counts as dropped if the old one
            // is not being committed this very cycle.
            if (bus.i_vec_valid) begin
                vec_buf <= bus.i_vec_data;
                pending <= 1'b1;
                dropped <= pending && (state != ST_VEC);
            end

            unique case (state)
                ST_IDLE: begin
                    if (vblank_rise) begin
                        if (pending)                state <= ST_VEC;
                        else if (fifo_count != '0)  state <= ST_REG;
                        else                        state <= ST_DONE;
                    end
                end
                ST_VEC: begin
                    wr_en   <= 1'b1;
                    wr_sel  <= WR_SEL_VEC;
                    wr_data <= vec_buf;
                    // A same-cycle push keeps pending set for the next frame.
                    if (!bus.i_vec_valid) pending <= 1'b0;
                    state <= (fifo_count != '0) ? ST_REG : ST_DONE;
                end
                ST_REG: begin
                    if (fifo_pop) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= WR_SEL_REG;
                        wr_addr <= head_addr;
                        wr_data <= VEC_W'(head_data);
                        state   <= (fifo_count == CW'(1)) ? ST_DONE : ST_REG;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_reg_ready   = !fifo_full;
    assign bus.o_reg_count   = fifo_count;
    assign bus.o_vec_pending = pending;
    assign bus.o_wr_en       = wr_en;
    assign bus.o_wr_sel      = wr_sel;
    assign bus.o_wr_addr     = wr_addr;
    assign bus.o_wr_data     = wr_data;
    assign bus.o_vec_dropped = dropped;
    assign bus.o_frame_done  = frame_done;

endmodule

// File: doc/rbz_update_arbiter.md
# rbz_update_arbiter

Frame-synchronous update scheduler for the raycaster's shared configuration register bank. It accepts write requests from two requesters, the vector SPI slave and the general register SPI slave, and buffers them. It then commits them through a single shared write port only during vertical blanking, so the renderer never sees a half-updated view mid-frame. It sits between the two SPI slave decoders and the rbzero register bank.

## Interface
Parameters:
- VEC_W, default 48: vector payload width (player position, facing, plane vectors). Must be ≥ REG_W.
- REG_W, default 16: general register data width.
- REG_AW, default 4: general register address width.
- DEPTH, default 4: general register queue depth. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system (pixel) clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_vblank  in  1  vertical blanking from the VGA timing generator.
- i_vec_valid  in  1  vector write request, single-cycle strobe.
- i_vec_data  in  VEC_W  vector payload.
- i_reg_valid  in  1  register write request.
- i_reg_addr  in  REG_AW  register address.
- i_reg_data  in  REG_W  register data.
- o_reg_ready  out  1  queue not full; a push is accepted only when i_reg_valid & o_reg_ready.
- o_wr_en  out  1  shared write port strobe.
- o_wr_sel  out  1  0 = vector write, 1 = register write.
- o_wr_addr  out  REG_AW  register address; 0 when o_wr_sel=0.
- o_wr_data  out  VEC_W  payload; register data is zero-extended.
- o_vec_pending  out  1  a vector update is buffered.
- o_reg_count  out  $clog2(DEPTH)+1  queued register writes.
- o_vec_dropped  out  1  one-cycle pulse when a pending vector is overwritten.
- o_frame_done  out  1  one-cycle pulse at the end of each commit window.

## Operation
- Vector buffer holds one entry, and the latest write wins.
  - i_vec_valid loads the buffer and sets pending.
  - If pending is already set and not being committed in that cycle, o_vec_dropped pulses.
  - The vector port is always ready.
- Register queue is a FIFO of {addr, data}, DEPTH entries.
  - o_reg_ready = (count < DEPTH), taken from the registered count.
  - A pop in the same cycle does not free space for a push.
- Vblank edge: vblank_q is i_vblank registered. edge = i_vblank & ~vblank_q.
- FSM states: IDLE, VEC, REG, DONE.
  - IDLE: on edge, go to VEC if pending, else REG if count > 0, else DONE.
  - VEC: o_wr_en=1, o_wr_sel=0, o_wr_data = buffer. Clear pending unless i_vec_valid in the same cycle (the new data stays pending for the next frame). Next state is REG if count > 0, else DONE.
  - REG, with i_vblank=1: o_wr_en=1, o_wr_sel=1, drive the queue head, then pop. Go to DONE when count==1 (last entry).
  - REG, with i_vblank=0: no write; go to DONE. Remaining entries wait for the next frame.
  - DONE: o_frame_done=1; go to IDLE.
- Writes are strictly ordered: vector first, then register entries in FIFO order.
- An edge seen outside IDLE is ignored.
- A push arriving during REG joins the tail and may be drained in the same window.
- The o_wr_* outputs decode from the state and storage registers only. There is no combinational path from an input to an output.

## Timing
- Reset values:
  - o_wr_en, o_wr_sel, o_wr_addr, o_wr_data, o_vec_pending, o_vec_dropped, o_frame_done are all 0.
  - o_reg_count = 0, o_reg_ready = 1.
  - State = IDLE, vblank_q = 0.
  - The queue is emptied and the vector buffer cleared.
- Edge timing: i_vblank rises at cycle N, the edge is seen at N+1, and the first write occurs at N+2.
- Commit duration: 1 (vector) + k (register writes) cycles, then o_frame_done one cycle later.
- Reset asserted mid-commit aborts at once. No further o_wr_en is produced, and uncommitted data is lost.
- Push-to-visibility latency: the o_vec_pending and o_reg_count updates appear the cycle after the push.

## Structure
- Shared package rbz_update_pkg: the FSM state enum, the WR_SEL_VEC/WR_SEL_REG constants, and the count-width helper.
- Sub-module rbz_sync_fifo: parameterised width and depth, synchronous reset, push/pop/count/empty/full. The register queue instantiates it.
- The FSM, vector buffer and edge detector live in rbz_update_arbiter.

## Test plan
- Reset, then vector 0x123456789ABC and register writes (3,0x00AA),(7,0x5501); raise i_vblank for 20 cycles. Expected: exactly 3 writes, in order vec, (3,0xAA), (7,0x5501), starting 2 cycles after the rise; o_frame_done is one pulse.
- Two vector pushes before vblank. Expected: o_vec_dropped pulses once, and only the second payload is written.
- Push 5 register writes with DEPTH=4. Expected: o_reg_ready drops after the 4th push, the 5th push is not accepted, and o_reg_count=4.
- 4 queued entries, i_vblank held high for only 3 cycles. Expected: vec plus 1 or 2 register writes (exact count per the edge timing), the rest committed in the next vblank, order preserved.
- i_vec_valid in the same cycle as the VEC state. Expected: the old payload is written, and o_vec_pending stays 1 carrying the new payload.
- Assert reset during REG. Expected: o_wr_en is 0 the following cycle, o_reg_count=0, and no o_frame_done.
